// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl
// Iterative AES-128 decryption sequencer. One ciphertext block is in flight
// at a time. A single shared inverse-round datapath runs one round per clock.
// Round keys are read from an external key-schedule store. That store answers
// in the same cycle as rk_addr is presented.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   ciphertext handshake (in_ready high only in IDLE)
//   ct[127:0]             ciphertext, byte 0 = [127:120]
//   rk_addr[3:0]          requested round-key index (NR down to 0)
//   rk_data[127:0]        round key for rk_addr
//   rk_valid              key store ready; low stalls the sequencer
//   pt[127:0]             plaintext, held after the block completes
//   out_valid / out_ready plaintext handshake
//   busy                  high whenever the FSM is not in IDLE
//   round[3:0]            current round index (debug)
//
// state | meaning
// IDLE  | waiting for a ciphertext block
// INIT  | initial AddRoundKey with key NR
// ROUND | full inverse rounds NR-1 .. 1
// FINAL | last round, no InvMixColumns
// DONE  | plaintext presented, waiting for out_ready
module aes_inv_cipher_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    output logic [3:0]   rk_addr,
    input  logic [127:0] rk_data,
    input  logic         rk_valid,
    output logic [127:0] pt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic [3:0]   round
);

    localparam logic [3:0] NR_L  = 4'(NR);
    localparam logic [3:0] NR_M1 = 4'(NR - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t       state;
    logic [127:0] st;
    logic [127:0] sub_shift;
    logic [127:0] key_add;
    logic [127:0] mix_out;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254. Zero maps to zero, as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse S-box: undo the affine map first, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // InvShiftRows rotates row r right by r. The output byte at (row r, col c)
    // comes from column (c - r) mod 4 of the current state.
    always_comb begin
        sub_shift = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_shift[127 - 8*(4*c + r) -: 8] =
                    inv_sbox(st[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
            end
        end
    end

    assign key_add = sub_shift ^ rk_data;

    always_comb begin
        mix_out = '0;
        for (int c = 0; c < 4; c++) begin
            mix_out[127 - 32*c -: 32] = inv_mix_col(key_add[127 - 32*c -: 32]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            st        <= '0;
            pt        <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            rk_addr   <= '0;
            round     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st       <= ct;
                        rk_addr  <= NR_L;
                        round    <= NR_L;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= INIT;
                    end
                end
                INIT: begin
                    if (rk_valid) begin
                        st      <= st ^ rk_data;
                        rk_addr <= NR_M1;
                        round   <= NR_M1;
                        state   <= ROUND;
                    end
                end
                ROUND: begin
                    if (rk_valid) begin
                        st      <= mix_out;
                        rk_addr <= rk_addr - 4'd1;
                        round   <= round - 4'd1;
                        if (round == 4'd1) state <= FINAL;
                    end
                end
                FINAL: begin
                    if (rk_valid) begin
                        st        <= key_add;
                        pt        <= key_add;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Self-checking bench for aes_inv_cipher_ctrl.
// The reference model is transaction-level. It counts the key-consuming
// cycles of each block and computes the plaintext with a table-driven
// byte-array AES decryption. A negedge process compares every DUT output
// against the model on every cycle.
module tb_aes_inv_cipher_ctrl;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         rk_valid;
    logic [127:0] pt;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic [3:0]   round;

    aes_inv_cipher_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .rk_addr   (rk_addr),
        .rk_data   (rk_data),
        .rk_valid  (rk_valid),
        .pt        (pt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .round     (round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit cmp_en = 0;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] rk_mem [16];
    logic [3:0]   addr_q [$];

    assign rk_data = rk_mem[rk_addr];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // Forward S-box by brute-force inversion plus the FIPS affine map,
    // then the inverse table by lookup reversal.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_mem[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [7:0] imc_coef(input int d);
        case (d)
            0: return 8'h0e;
            1: return 8'h0b;
            2: return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    function automatic logic [127:0] ref_decrypt(input logic [127:0] c);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   acc;
        logic [127:0] k;
        logic [127:0] res;
        k = rk_mem[10];
        for (int i = 0; i < 16; i++) s[i] = c[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
        for (int r = 9; r >= 0; r--) begin
            k = rk_mem[r];
            for (int col = 0; col < 4; col++)
                for (int row = 0; row < 4; row++)
                    t[4*col + row] = isb[s[4*((col - row + 4) % 4) + row]] ^ k[127 - 8*(4*col + row) -: 8];
            for (int col = 0; col < 4; col++)
                for (int row = 0; row < 4; row++) begin
                    if (r > 0) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++)
                            acc = acc ^ gmul(t[4*col + j], imc_coef((j - row + 4) % 4));
                        s[4*col + row] = acc;
                    end else begin
                        s[4*col + row] = t[4*col + row];
                    end
                end
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // Transaction model: mode 0 idle, 1 consuming keys (m_k keys used), 2 done.
    int           m_mode;
    int           m_k;
    logic [127:0] m_ct;
    logic [127:0] m_pt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0;
            m_k    <= 0;
            m_pt   <= '0;
        end else begin
            case (m_mode)
                0: if (in_valid) begin
                    m_mode <= 1;
                    m_k    <= 0;
                    m_ct   <= ct;
                end
                1: if (rk_valid) begin
                    if (m_k == 10) begin
                        m_mode <= 2;
                        m_pt   <= ref_decrypt(m_ct);
                    end else begin
                        m_k <= m_k + 1;
                    end
                end
                default: if (out_ready) m_mode <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready",  in_ready,  m_mode == 0);
            chk("busy",      busy,      m_mode != 0);
            chk("out_valid", out_valid, m_mode == 2);
            chk("pt",        pt,        m_pt);
            chk("rk_addr",   rk_addr,   (m_mode == 1) ? (10 - m_k) : 0);
            chk("round",     round,     (m_mode == 1) ? (10 - m_k) : 0);
        end
    end

    // Offers one block, scrambles in_valid/ct while busy, applies the stall mask
    // (bit n = rk_valid low in the n-th cycle after accept) and holds out_ready
    // low for bp cycles of out_valid.
    task automatic run_block(input logic [127:0] c, input logic [31:0] stall, input int bp,
                             output int lat, output int held);
        int  w;
        int  n;
        bit  seen;
        bit  fin;
        lat  = -1;
        held = 0;
        addr_q.delete();
        @(negedge clk);
        in_valid  = 1'b1;
        ct        = c;
        rk_valid  = 1'b1;
        out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        n = 0;
        seen = 0;
        fin = 0;
        while (!fin && n < 300) begin
            @(negedge clk);
            n++;
            if (busy && !out_valid) addr_q.push_back(rk_addr);
            if (out_valid && !seen) begin
                seen = 1;
                lat = n;
            end
            if (seen && !out_valid) begin
                fin = 1;
            end else if (out_valid) begin
                in_valid  = 1'b0;
                out_ready = (held >= bp);
                held++;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                ct       = {$urandom, $urandom, $urandom, $urandom};
                rk_valid = (n < 32) ? !stall[n] : 1'b1;
            end
        end
        if (!fin) chk("block_timeout", fin, 1);
        else      chk("idle_after_handshake", in_ready, 1);
        in_valid  = 1'b0;
        rk_valid  = 1'b1;
        out_ready = 1'b0;
    endtask

    int         lat;
    int         held;
    int         acc_q [$];
    int         w;
    logic [127:0] rc;

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        ct = '0;
        rk_valid = 1'b1;
        out_ready = 1'b0;
        build_sbox();
        expand(KEY1);
        #1 rst = 1'b1;
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_pt", pt, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rk_addr", rk_addr, 0);
        chk("reset_round", round, 0);
        cmp_en = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Hand-computed pins of the model itself.
        chk("model_sbox_00", sb[0], 8'h63);
        chk("model_sbox_53", sb[8'h53], 8'hed);
        chk("model_isbox_00", isb[0], 8'h52);
        chk("model_rk10", rk_mem[10], RK10);
        chk("model_c1", ref_decrypt(CT1), PT1);

        // FIPS-197 C.1, no stalls.
        run_block(CT1, 32'h0, 0, lat, held);
        chk("c1_latency", lat, 12);
        chk("c1_pt", pt, PT1);
        chk("c1_addr_count", addr_q.size(), 11);
        for (int i = 0; i < addr_q.size() && i < 11; i++)
            chk("c1_addr_seq", addr_q[i], 10 - i);

        // One stall in INIT, three in ROUND with round=5.
        run_block(CT1, 32'h0000_0382, 0, lat, held);
        chk("stall_latency", lat, 16);
        chk("stall_pt", pt, PT1);

        // Output backpressure for 20 cycles.
        run_block(CT1, 32'h0, 20, lat, held);
        chk("bp_held", held, 21);
        chk("bp_pt", pt, PT1);

        // Back-to-back with in_valid held high.
        @(negedge clk);
        ct = CT1;
        in_valid = 1'b1;
        rk_valid = 1'b1;
        out_ready = 1'b1;
        acc_q.delete();
        for (int i = 0; i < 40; i++) begin
            if (in_ready && in_valid) acc_q.push_back(cyc);
            if (out_valid) chk("b2b_pt", pt, PT1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_accepts", acc_q.size() >= 2, 1);
        if (acc_q.size() >= 2) chk("b2b_interval", acc_q[1] - acc_q[0], 13);
        w = 0;
        while (!(in_ready && !out_valid) && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("b2b_drain", in_ready, 1);
        out_ready = 1'b0;

        // Reset in the middle of round 6.
        @(negedge clk);
        ct = CT1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (round != 4'd6 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("rst_reach_round6", round, 6);
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rk_addr", rk_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        run_block(CT1, 32'h0, 1, lat, held);
        chk("post_rst_latency", lat, 12);
        chk("post_rst_pt", pt, PT1);

        // Randomized keys, ciphertexts, stalls and backpressure.
        for (int b = 0; b < 8; b++) begin
            expand({$urandom, $urandom, $urandom, $urandom});
            rc = {$urandom, $urandom, $urandom, $urandom};
            run_block(rc, $urandom & $urandom & $urandom & 32'hffff_fffe, int'($urandom_range(0, 4)), lat, held);
            chk("rand_pt", pt, ref_decrypt(rc));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
# aes_inv_cipher_ctrl

Iterative AES-128 decryption sequencer. It accepts one 128-bit ciphertext block per transaction and runs the ten inverse rounds over a single shared inverse-round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns), one round per clock. Round keys are fetched from the precomputed key-schedule store through a read port. It sits between the decryption input FIFO and the plaintext output stage.

## Interface
- NR, 10, number of rounds; only 10 is legal (AES-128); rk_addr counts NR down to 0
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ciphertext offered
- in_ready  out  1  controller can accept; high only in IDLE
- ct  in  128  ciphertext; byte 0 = [127:120]; column c = bits [127-32c -: 32]
- rk_addr  out  4  round-key index requested; registered
- rk_data  in  128  round key for rk_addr; combinational (same-cycle) read
- rk_valid  in  1  key store has valid data; low = stall
- pt  out  128  plaintext; registered, stable while out_valid
- out_valid  out  1  pt valid
- out_ready  in  1  downstream accepts pt
- busy  out  1  high in any state other than IDLE
- round  out  4  current round index, for debug

## Operation
- Internal 128-bit state register `st` and FSM with states IDLE, INIT, ROUND, FINAL, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture ct into st, set rk_addr<=NR and round<=NR, go to INIT.
- INIT: if rk_valid, set st<=st^rk_data, rk_addr<=NR-1, round<=NR-1, go to ROUND.
- ROUND (round 9..1): if rk_valid, set st<=InvMixColumns(InvSubBytes(InvShiftRows(st))^rk_data) and decrement rk_addr and round. When round==1, go to FINAL, with rk_addr=0.
- FINAL (round 0): if rk_valid, set st<=InvSubBytes(InvShiftRows(st))^rk_data, which applies no InvMixColumns. Set pt<=that value, set out_valid<=1, go to DONE.
- DONE: hold pt and out_valid. On out_ready, clear out_valid and go to IDLE. pt keeps its last value.
- Stall: in INIT, ROUND or FINAL with rk_valid=0, st, rk_addr, round and the state are all unchanged.
- InvMixColumns matrix per column is [0e 0b 0d 09; 09 0e 0b 0d; 0d 09 0e 0b; 0b 0d 09 0e] over GF(2^8), with reduction polynomial 0x11b. The four columns are independent.
- in_valid while not IDLE is ignored, because in_ready=0. The upstream block must hold ct until the handshake.
- Only one block is in flight at a time. There is no abort; rst is the only way to cancel.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, pt=0, st=0, rk_addr=0, round=0, busy=0.
- The reset is asynchronous: outputs go to their reset values immediately, with no wait for a clock edge. Deassertion is synchronised externally.
- Reset mid-operation: the current block is discarded and no out_valid is produced. The next block starts from IDLE.
- Latency with rk_valid held high: the accept edge is T0; INIT is at T0+1, ROUND at T0+2..T0+10, FINAL at T0+11, and out_valid=1 from T0+12. Each stall cycle adds 1.
- Minimum initiation interval is 13 cycles, assuming out_ready is already high when out_valid rises (DONE→IDLE takes 1 cycle).
- rk_addr changes only on the clock edge. The key store must present rk_data for the current rk_addr within the same cycle.
- busy=1 from T0+1 until the edge on which the out_ready handshake completes.

## Test plan
- FIPS-197 C.1: ct=69c4e0d86a7b0430d8cdb78070b4c55a, key schedule of key 000102030405060708090a0b0c0d0e0f, rk_valid=1, out_ready=1 → pt=00112233445566778899aabbccddeeff with out_valid at T0+12. Also check rk_addr sequence 10,9,…,0.
- Zero-vector stall: same vectors, but rk_valid dropped for 3 cycles in ROUND(round=5) and 1 cycle in INIT → same pt, out_valid at T0+16, and st/rk_addr frozen during the stalls.
- Output backpressure: out_ready=0 for 20 cycles after out_valid → pt stable, in_ready=0 throughout. Then out_ready=1 for one cycle → IDLE and in_ready=1 on the next cycle.
- Back-to-back: two C.1 blocks offered continuously with in_valid=1 → second accept exactly 13 cycles after the first; both pt correct.
- Reset mid-operation: assert rst at round=6 → out_valid=0, in_ready=1, busy=0 immediately. A new block after release decrypts correctly.
- Ignored input: toggle in_valid/ct during ROUND → no effect on the result; the captured ct is used.
